// File: rtl/game_pkg.sv
// Shared constants, state encoding and helpers for the game sequencer.
// The FSM state values are also the values driven on game_state.
package game_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PLAY   = 2'd1;
    localparam logic [1:0] ST_FREEZE = 2'd2;
    localparam logic [1:0] ST_OVER   = 2'd3;

    localparam int unsigned ROUND_SEC_DEF  = 60;
    localparam int unsigned LIVES_INIT_DEF = 3;
    localparam int unsigned FREEZE_SEC_DEF = 2;
    localparam int unsigned WIN_SCORE_DEF  = 50;

    typedef struct packed {
        logic [1:0] state;
        logic [7:0] score;
        logic [1:0] lives;
        logic [6:0] time_left;
        logic       win;
    } game_status_t;

    // Score counter stops at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rise_det.sv
// One-bit rising-edge detector with a history register.
// A level already high when reset is released is never reported as an edge.
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_prev;
    logic r_armed;

    // History of the input; arming requires the input to have been seen low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev <= i_d;
            if (!i_d) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_rise = i_d & ~r_prev & r_armed;

endmodule

// File: rtl/game_sequencer.sv
// Round controller: IDLE/PLAY/FREEZE/OVER state machine with score, lives,
// round timer and freeze counter. All outputs come straight from registers.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned ROUND_SEC  = ROUND_SEC_DEF,
    parameter int unsigned LIVES_INIT = LIVES_INIT_DEF,
    parameter int unsigned FREEZE_SEC = FREEZE_SEC_DEF,
    parameter int unsigned WIN_SCORE  = WIN_SCORE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       start_btn,
    input  logic [1:0] event_in,
    output logic       move_en,
    output logic [1:0] game_state,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [6:0] time_left,
    output logic       win
);

    localparam logic [6:0] L_ROUND  = 7'(ROUND_SEC);
    localparam logic [1:0] L_LIVES  = 2'(LIVES_INIT);
    localparam logic [6:0] L_FREEZE = 7'(FREEZE_SEC);
    localparam logic [7:0] L_WIN    = 8'(WIN_SCORE);

    logic       w_start_rise;
    logic       w_hit_rise;
    logic       w_touch_rise;

    logic [1:0] r_state;
    logic [7:0] r_score;
    logic [1:0] r_lives;
    logic [6:0] r_time;
    logic       r_win;
    logic       r_move_en;
    logic [6:0] r_frz;

    logic [1:0] w_state;
    logic [7:0] w_score;
    logic [1:0] w_lives;
    logic [6:0] w_time;
    logic       w_win;
    logic [6:0] w_frz;

    logic [7:0] w_play_score;
    logic [1:0] w_play_lives;
    logic [6:0] w_play_time;
    logic       w_lost;
    logic       w_won;
    logic       w_timeout;

    rise_det u_start (.clk(clk), .rst(rst), .i_d(start_btn),   .o_rise(w_start_rise));
    rise_det u_hit   (.clk(clk), .rst(rst), .i_d(event_in[1]), .o_rise(w_hit_rise));
    rise_det u_touch (.clk(clk), .rst(rst), .i_d(event_in[0]), .o_rise(w_touch_rise));

    // Candidate counter values if the current cycle is spent in PLAY.
    assign w_play_score = w_hit_rise ? sat_inc8(r_score) : r_score;
    assign w_play_lives = w_touch_rise ? (r_lives - 2'd1) : r_lives;
    assign w_play_time  = (tick_1hz && (r_time != 7'd0)) ? (r_time - 7'd1) : r_time;
    assign w_lost       = w_touch_rise && (w_play_lives == 2'd0);
    assign w_won        = w_hit_rise && (w_play_score == L_WIN);
    assign w_timeout    = tick_1hz && (r_time == 7'd1);

    // Next-state and counter update; loss outranks win, win outranks timeout.
    always_comb begin
        w_state = r_state;
        w_score = r_score;
        w_lives = r_lives;
        w_time  = r_time;
        w_win   = r_win;
        w_frz   = r_frz;
        case (r_state)
            ST_IDLE: begin
                w_score = 8'd0;
                w_lives = L_LIVES;
                w_time  = L_ROUND;
                w_win   = 1'b0;
                w_frz   = 7'd0;
                if (w_start_rise) begin
                    w_state = ST_PLAY;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_PLAY: begin
                w_score = w_play_score;
                w_lives = w_play_lives;
                w_time  = w_play_time;
                if (w_lost) begin
                    w_state = ST_OVER;
                    w_win   = 1'b0;
                end else if (w_won || w_timeout) begin
                    w_state = ST_OVER;
                    w_win   = 1'b1;
                end else if (w_touch_rise) begin
                    w_state = ST_FREEZE;
                    w_frz   = L_FREEZE;
                end else begin
                    w_state = ST_PLAY;
                end
            end
            ST_FREEZE: begin
                if (tick_1hz) begin
                    if (r_frz <= 7'd1) begin
                        w_frz   = 7'd0;
                        w_state = ST_PLAY;
                    end else begin
                        w_frz   = r_frz - 7'd1;
                        w_state = ST_FREEZE;
                    end
                end else begin
                    w_state = ST_FREEZE;
                end
            end
            ST_OVER: begin
                if (w_start_rise) begin
                    w_state = ST_IDLE;
                    w_score = 8'd0;
                    w_lives = L_LIVES;
                    w_time  = L_ROUND;
                    w_win   = 1'b0;
                    w_frz   = 7'd0;
                end else begin
                    w_state = ST_OVER;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_score = 8'd0;
                w_lives = L_LIVES;
                w_time  = L_ROUND;
                w_win   = 1'b0;
                w_frz   = 7'd0;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_score   <= 8'd0;
            r_lives   <= L_LIVES;
            r_time    <= L_ROUND;
            r_win     <= 1'b0;
            r_move_en <= 1'b0;
            r_frz     <= 7'd0;
        end else begin
            r_state   <= w_state;
            r_score   <= w_score;
            r_lives   <= w_lives;
            r_time    <= w_time;
            r_win     <= w_win;
            r_move_en <= (w_state == ST_PLAY);
            r_frz     <= w_frz;
        end
    end

    assign move_en    = r_move_en;
    assign game_state = r_state;
    assign score      = r_score;
    assign lives      = r_lives;
    assign time_left  = r_time;
    assign win        = r_win;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a behavioural model queues the
// expected status for every driven cycle, compared after the clock edge.
module tb_game_sequencer;

    localparam int ROUND  = 60;
    localparam int LIVES0 = 3;
    localparam int FRZ    = 2;
    localparam int WINSC  = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       start_btn = 1'b0;
    logic [1:0] event_in = 2'b00;
    logic       move_en;
    logic [1:0] game_state;
    logic [7:0] score;
    logic [1:0] lives;
    logic [6:0] time_left;
    logic       win;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int st;
        int sc;
        int lv;
        int tl;
        int wn;
        int mv;
    } exp_t;

    exp_t exp_q[$];

    // Model state
    int m_st, m_sc, m_lv, m_tl, m_wn, m_mv, m_frz;
    bit mp_s, mp_h, mp_t, ma_s, ma_h, ma_t;

    game_sequencer #(
        .ROUND_SEC(ROUND), .LIVES_INIT(LIVES0), .FREEZE_SEC(FRZ), .WIN_SCORE(WINSC)
    ) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .start_btn(start_btn),
        .event_in(event_in), .move_en(move_en), .game_state(game_state),
        .score(score), .lives(lives), .time_left(time_left), .win(win)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, expv);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_sc = 0; m_lv = LIVES0; m_tl = ROUND; m_wn = 0; m_mv = 0; m_frz = 0;
        mp_s = 0; mp_h = 0; mp_t = 0; ma_s = 0; ma_h = 0; ma_t = 0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit [1:0] ev, input bit t);
        bit se, he, te;
        if (r) begin
            model_reset();
            return;
        end
        se = s && !mp_s && ma_s;
        he = ev[1] && !mp_h && ma_h;
        te = ev[0] && !mp_t && ma_t;
        mp_s = s; mp_h = ev[1]; mp_t = ev[0];
        if (!s) ma_s = 1;
        if (!ev[1]) ma_h = 1;
        if (!ev[0]) ma_t = 1;
        if (m_st == 0) begin
            if (se) m_st = 1;
        end else if (m_st == 1) begin
            if (he && m_sc < 255) m_sc = m_sc + 1;
            if (te) m_lv = m_lv - 1;
            if (t) m_tl = m_tl - 1;
            if (te && m_lv == 0) begin m_st = 3; m_wn = 0; end
            else if (he && m_sc == WINSC) begin m_st = 3; m_wn = 1; end
            else if (t && m_tl == 0) begin m_st = 3; m_wn = 1; end
            else if (te) begin m_st = 2; m_frz = FRZ; end
        end else if (m_st == 2) begin
            if (t) begin
                m_frz = m_frz - 1;
                if (m_frz == 0) m_st = 1;
            end
        end else begin
            if (se) begin
                m_st = 0; m_sc = 0; m_lv = LIVES0; m_tl = ROUND; m_wn = 0; m_frz = 0;
            end
        end
        m_mv = (m_st == 1) ? 1 : 0;
    endtask

    // Drive one clock of stimulus, queue the expectation, then score the DUT.
    task automatic step(input bit r, input bit s, input bit [1:0] ev, input bit t);
        exp_t e, g;
        @(negedge clk);
        rst = r; start_btn = s; event_in = ev; tick_1hz = t;
        model_step(r, s, ev, t);
        e.st = m_st; e.sc = m_sc; e.lv = m_lv; e.tl = m_tl; e.wn = m_wn; e.mv = m_mv;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        chk("state", int'(game_state), g.st);
        chk("score", int'(score), g.sc);
        chk("lives", int'(lives), g.lv);
        chk("time_left", int'(time_left), g.tl);
        chk("move_en", int'(move_en), g.mv);
        if (g.st == 3) chk("win", int'(win), g.wn);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 2'b00, 0);
    endtask

    task automatic press_start();
        step(0, 1, 2'b00, 0);
        step(0, 0, 2'b00, 0);
    endtask

    task automatic pulse_ev(input bit [1:0] ev, input int hold);
        for (int i = 0; i < hold; i++) step(0, 0, ev, 0);
        step(0, 0, 2'b00, 0);
    endtask

    initial begin
        model_reset();
        // Reset state
        step(1, 0, 2'b00, 0);
        step(1, 0, 2'b00, 0);
        chk("rst_state", int'(game_state), 0);
        chk("rst_lives", int'(lives), LIVES0);
        chk("rst_time", int'(time_left), ROUND);
        idle(2);

        // Full round with no events: survive on timeout
        press_start();
        chk("play_entered", int'(game_state), 1);
        for (int i = 0; i < ROUND; i++) begin
            step(0, 0, 2'b00, 1);
            idle(1);
        end
        chk("timeout_state", int'(game_state), 3);
        chk("timeout_win", int'(win), 1);
        chk("timeout_time", int'(time_left), 0);
        chk("timeout_score", int'(score), 0);

        // Held hit pulses reach WIN_SCORE
        press_start();
        chk("over_to_idle", int'(game_state), 0);
        press_start();
        for (int i = 0; i < WINSC; i++) pulse_ev(2'b10, 10);
        chk("hits_score", int'(score), WINSC);
        chk("hits_state", int'(game_state), 3);
        chk("hits_win", int'(win), 1);

        // Touch -> FREEZE, ignored hits, resume after FRZ ticks
        press_start();
        press_start();
        step(0, 0, 2'b00, 1);
        pulse_ev(2'b01, 3);
        chk("touch_lives", int'(lives), 2);
        chk("touch_state", int'(game_state), 2);
        chk("touch_move_en", int'(move_en), 0);
        pulse_ev(2'b10, 2);
        pulse_ev(2'b10, 1);
        chk("freeze_no_score", int'(score), 0);
        step(0, 0, 2'b00, 1);
        chk("freeze_hold", int'(game_state), 2);
        step(0, 0, 2'b00, 1);
        chk("freeze_done", int'(game_state), 1);
        chk("freeze_time", int'(time_left), ROUND - 1);

        // Reach lives=1, score=49, then hit+touch in the same cycle
        pulse_ev(2'b01, 1);
        step(0, 0, 2'b00, 1);
        step(0, 0, 2'b00, 1);
        for (int i = 0; i < WINSC - 1; i++) pulse_ev(2'b10, 1);
        chk("pre_lives", int'(lives), 1);
        chk("pre_score", int'(score), WINSC - 1);
        pulse_ev(2'b11, 2);
        chk("tie_score", int'(score), WINSC);
        chk("tie_lives", int'(lives), 0);
        chk("tie_state", int'(game_state), 3);
        chk("tie_win", int'(win), 0);

        // Reset mid-FREEZE with start held through release
        press_start();
        press_start();
        pulse_ev(2'b01, 1);
        chk("mid_freeze", int'(game_state), 2);
        step(0, 1, 2'b00, 0);
        step(1, 1, 2'b00, 0);
        step(1, 1, 2'b00, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 2'b00, 0);
        chk("held_start_idle", int'(game_state), 0);
        chk("held_start_lives", int'(lives), LIVES0);
        chk("held_start_time", int'(time_left), ROUND);
        step(0, 0, 2'b00, 0);
        chk("released_idle", int'(game_state), 0);
        press_start();
        chk("restart_play", int'(game_state), 1);
        chk("restart_move_en", int'(move_en), 1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter ROUND_SEC, 60, round length in 1 Hz ticks (7 bits).
REQ-002 SHALL have parameter LIVES_INIT, 3, lives at round start (2 bits, nonzero).
REQ-003 SHALL have parameter FREEZE_SEC, 2, pause length after a life loss, in ticks.
REQ-004 SHALL have parameter WIN_SCORE, 50, score that ends the round as a win (8 bits).
REQ-005 SHALL have one clock and a synchronous, active-high reset (the polarity and synchronicity are fixed): clk  input  1  system clock; rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port tick_1hz  input  1  one-clk enable pulse, once per second.
REQ-007 SHALL have port start_btn  input  1  debounced start/restart level.
REQ-008 SHALL have port event_in  input  2  [1] missile hit dragon, [0] dragon touched robot (levels, may stay high several cycles).
REQ-009 SHALL have port move_en  output  1  movement/shoot enable for the dragon, robot and missile movers.
REQ-010 SHALL have port game_state  output  2  IDLE=0, PLAY=1, FREEZE=2, OVER=3.
REQ-011 SHALL have ports score  output  8, lives  output  2, time_left  output  7, win  output  1  (win valid only in OVER).

Function
REQ-012 SHALL rising-edge-detect start_btn, event_in[1] and event_in[0] internally; each rising edge is one event, with no latency beyond the detector register.
REQ-013 SHALL, in IDLE, hold score=0, lives=LIVES_INIT, time_left=ROUND_SEC and move_en=0, and go to PLAY on a start edge.
REQ-014 SHALL, in PLAY, drive move_en=1 and decrement time_left by 1 on each tick_1hz.
REQ-015 SHALL, in PLAY on a hit edge, increment score; score SHALL saturate at 255.
REQ-016 SHALL, in PLAY on a touch edge, decrement lives; if the result is 0 go to OVER with win=0, else go to FREEZE and load the freeze counter with FREEZE_SEC.
REQ-017 SHALL, in PLAY when score reaches WIN_SCORE after an update, go to OVER with win=1.
REQ-018 SHALL, in PLAY on a tick while time_left==1, set time_left=0 and go to OVER with win=1 (survived round).
REQ-019 SHALL apply this priority when events coincide in one cycle: both the hit and touch counters update; then lives==0 overrides, then WIN_SCORE, then timeout; a loss beats a win.
REQ-020 SHALL, in FREEZE, drive move_en=0, ignore hit and touch edges, hold time_left, decrement the freeze counter on tick_1hz, and return to PLAY on the tick that makes it 0.
REQ-021 SHALL, in OVER, drive move_en=0, hold score, lives, time_left and win, and go to IDLE on a start edge; the next start edge then enters PLAY.
REQ-022 SHALL ignore start edges in PLAY and FREEZE.
REQ-023 SHALL drive all outputs from registers; a state change is visible one clk after the causing edge or tick.

Reset
REQ-024 SHALL, with rst high at a clk edge, force IDLE, score=0, lives=LIVES_INIT, time_left=ROUND_SEC, win=0, move_en=0, freeze counter=0 and the edge-detector history to 0; rst SHALL override every other input.
REQ-025 SHALL, when rst is asserted mid-PLAY or mid-FREEZE, abandon the round with no residual event; a start_btn level held through the rst release SHALL NOT produce a start edge.

Structure
REQ-026 SHALL take the state encoding and the default constants from a shared package, game_pkg.
REQ-027 SHALL use one sub-module, rise_det (1-bit registered rising-edge detector), instantiated 3 times; the state machine and counters SHALL be in game_sequencer.

Verification
REQ-028 SHALL cover: rst, start pulse, 60 ticks with no events -> PLAY for 60 ticks, then OVER, win=1, time_left=0, score=0.
REQ-029 SHALL cover: event_in[1] held high 10 clks, 50 times in PLAY -> score increments once per pulse; at 50 -> OVER, win=1.
REQ-030 SHALL cover: touch pulse in PLAY with lives=3 -> lives=2, FREEZE, move_en=0; hit pulses in FREEZE ignored; PLAY after 2 ticks; time_left frozen.
REQ-031 SHALL cover: hit and touch in the same cycle with lives=1 and score=49 -> score=50, lives=0, OVER, win=0.
REQ-032 SHALL cover: rst mid-FREEZE with start_btn held high -> IDLE with all reset values; no PLAY until start_btn falls and rises again.
